// File: rtl/ps2_key_state.sv
// PS/2 keyboard receiver for the Pong paddle controls.
// Synchronises the raw PS/2 lines into iVGA_CLK, deframes 11-bit frames
// and tracks the held/released state of the W, S, O and L keys.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for a start bit (data low on a PS/2 falling edge)
// S_SHIFT  | collecting D0..D7, LSB first
// S_PARITY | waiting for the odd-parity bit
// S_STOP   | waiting for the stop bit; frame is judged on this edge
module ps2_key_state #(
  parameter int          TIMEOUT_CYCLES = 25000,
  parameter logic [7:0]  SC_W           = 8'h1D,
  parameter logic [7:0]  SC_S           = 8'h1B,
  parameter logic [7:0]  SC_O           = 8'h44,
  parameter logic [7:0]  SC_L           = 8'h4B
) (
  input  logic       iVGA_CLK,
  input  logic       iRST_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       w_out,
  output logic       s_out,
  output logic       o_out,
  output logic       l_out,
  output logic       code_valid,
  output logic [7:0] code_byte,
  output logic       frame_err
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] BRK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE = 8'hE0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic            r_clk_s1;
  logic            r_clk_s2;
  logic            r_clk_prev;
  logic            r_dat_s1;
  logic            r_dat_s2;
  logic            w_fall;

  logic [2:0]      r_bit_cnt;
  logic [2:0]      w_bit_cnt_nxt;
  logic [7:0]      r_sh;
  logic [7:0]      w_sh_nxt;
  logic            r_par;
  logic            w_par_nxt;
  logic [CW-1:0]   r_to_cnt;
  logic [CW-1:0]   w_to_cnt_nxt;

  logic            w_good;
  logic            w_err;

  logic            r_brk;
  logic            r_ext;

  assign w_fall = r_clk_prev & ~r_clk_s2;

  // Two-flop synchronisers plus the delayed clock used for edge detection.
  // Idle-high lines reset to 1 so release from reset never fakes an edge.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_clk_prev <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
    end else begin
      r_clk_s1   <= ps2_clk;
      r_clk_s2   <= r_clk_s1;
      r_clk_prev <= r_clk_s2;
      r_dat_s1   <= ps2_data;
      r_dat_s2   <= r_dat_s1;
    end
  end

  // Frame FSM state, shift register and inactivity counter.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= 3'd0;
      r_sh      <= 8'h00;
      r_par     <= 1'b0;
      r_to_cnt  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_sh      <= w_sh_nxt;
      r_par     <= w_par_nxt;
      r_to_cnt  <= w_to_cnt_nxt;
    end
  end

  // Next-state logic: bit collection on PS/2 falling edges, frame checks
  // on the stop edge, and abort of a stalled partial frame.
  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_sh_nxt      = r_sh;
    w_par_nxt     = r_par;
    w_to_cnt_nxt  = r_to_cnt;
    w_good        = 1'b0;
    w_err         = 1'b0;

    if (w_fall) begin
      case (r_state)
        S_IDLE: begin
          if (!r_dat_s2) begin
            w_state_nxt   = S_SHIFT;
            w_bit_cnt_nxt = 3'd0;
          end
        end
        S_SHIFT: begin
          w_sh_nxt      = {r_dat_s2, r_sh[7:1]};
          w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            w_state_nxt = S_PARITY;
          end
        end
        S_PARITY: begin
          w_par_nxt   = r_dat_s2;
          w_state_nxt = S_STOP;
        end
        S_STOP: begin
          w_state_nxt = S_IDLE;
          if ((^{r_sh, r_par}) && r_dat_s2) begin
            w_good = 1'b1;
          end else begin
            w_err = 1'b1;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end

    // A falling edge always restarts the inactivity window; the window
    // only runs while a frame is in progress.
    if (r_state == S_IDLE || w_fall) begin
      w_to_cnt_nxt = '0;
    end else if (r_to_cnt == TO_LAST) begin
      w_state_nxt   = S_IDLE;
      w_bit_cnt_nxt = 3'd0;
      w_sh_nxt      = 8'h00;
      w_par_nxt     = 1'b0;
      w_to_cnt_nxt  = '0;
      w_err         = 1'b1;
    end else begin
      w_to_cnt_nxt  = r_to_cnt + 1'b1;
    end
  end

  // Byte decoder: registered pulses, last good byte, break/extended
  // prefix flags and the four key levels.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      code_valid <= 1'b0;
      code_byte  <= 8'h00;
      frame_err  <= 1'b0;
      r_brk      <= 1'b0;
      r_ext      <= 1'b0;
      w_out      <= 1'b0;
      s_out      <= 1'b0;
      o_out      <= 1'b0;
      l_out      <= 1'b0;
    end else begin
      code_valid <= w_good;
      frame_err  <= w_err;
      if (w_err) begin
        r_brk <= 1'b0;
        r_ext <= 1'b0;
      end else if (w_good) begin
        code_byte <= r_sh;
        if (r_sh == BRK_CODE) begin
          r_brk <= 1'b1;
        end else if (r_sh == EXT_CODE) begin
          r_ext <= 1'b1;
        end else begin
          // Extended-prefixed codes are other keys that share these low bytes.
          if (!r_ext) begin
            if (r_sh == SC_W) w_out <= ~r_brk;
            if (r_sh == SC_S) s_out <= ~r_brk;
            if (r_sh == SC_O) o_out <= ~r_brk;
            if (r_sh == SC_L) l_out <= ~r_brk;
          end
          r_brk <= 1'b0;
          r_ext <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_state.sv
// Directed bench for ps2_key_state: table of PS/2 frames with expected key
// levels and pulse counts, plus timeout and mid-frame reset sequences.
module tb_ps2_key_state;

  localparam int TO   = 200;
  localparam int HALF = 4;

  logic       clk;
  logic       rst_n;
  logic       ps2_clk;
  logic       ps2_data;
  logic       w_out, s_out, o_out, l_out;
  logic       code_valid;
  logic [7:0] code_byte;
  logic       frame_err;
  logic [3:0] keys;

  int n_chk  = 0;
  int n_fail = 0;
  int n_valid = 0;
  int n_err   = 0;
  logic [3:0] keys_at_valid = 4'h0;

  assign keys = {w_out, s_out, o_out, l_out};

  ps2_key_state #(.TIMEOUT_CYCLES(TO)) dut (
    .iVGA_CLK   (clk),
    .iRST_n     (rst_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .w_out      (w_out),
    .s_out      (s_out),
    .o_out      (o_out),
    .l_out      (l_out),
    .code_valid (code_valid),
    .code_byte  (code_byte),
    .frame_err  (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters sampled away from the active edge.
  always @(negedge clk) begin
    if (code_valid) begin
      n_valid = n_valid + 1;
      keys_at_valid = keys;
    end
    if (frame_err) n_err = n_err + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    ps2_data = b;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic bad_stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit((~^d) ^ bad_par);
    send_bit(~bad_stop);
    ps2_data = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] b;
    logic       bp;
    logic       bs;
    logic [3:0] keys;
    int         dv;
    int         de;
    logic [7:0] byte_exp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int v0, e0;
    // keys are {w, s, o, l}
    vecs.push_back('{8'h1D, 1'b0, 1'b0, 4'b1000, 1, 0, 8'h1D});
    vecs.push_back('{8'hF0, 1'b0, 1'b0, 4'b1000, 1, 0, 8'hF0});
    vecs.push_back('{8'h1D, 1'b0, 1'b0, 4'b0000, 1, 0, 8'h1D});
    vecs.push_back('{8'h1D, 1'b0, 1'b0, 4'b1000, 1, 0, 8'h1D});
    vecs.push_back('{8'h1D, 1'b0, 1'b0, 4'b1000, 1, 0, 8'h1D});
    vecs.push_back('{8'h44, 1'b0, 1'b0, 4'b1010, 1, 0, 8'h44});
    vecs.push_back('{8'hF0, 1'b0, 1'b0, 4'b1010, 1, 0, 8'hF0});
    vecs.push_back('{8'h1D, 1'b0, 1'b0, 4'b0010, 1, 0, 8'h1D});
    vecs.push_back('{8'h1B, 1'b1, 1'b0, 4'b0010, 0, 1, 8'h1D});
    vecs.push_back('{8'h1B, 1'b0, 1'b1, 4'b0010, 0, 1, 8'h1D});
    vecs.push_back('{8'hF0, 1'b0, 1'b0, 4'b0010, 1, 0, 8'hF0});
    vecs.push_back('{8'h1B, 1'b0, 1'b0, 4'b0010, 1, 0, 8'h1B});
    vecs.push_back('{8'hE0, 1'b0, 1'b0, 4'b0010, 1, 0, 8'hE0});
    vecs.push_back('{8'h4B, 1'b0, 1'b0, 4'b0010, 1, 0, 8'h4B});
    vecs.push_back('{8'hF0, 1'b0, 1'b0, 4'b0010, 1, 0, 8'hF0});
    vecs.push_back('{8'h1B, 1'b1, 1'b0, 4'b0010, 0, 1, 8'hF0});
    vecs.push_back('{8'h4B, 1'b0, 1'b0, 4'b0011, 1, 0, 8'h4B});
    vecs.push_back('{8'hF0, 1'b0, 1'b0, 4'b0011, 1, 0, 8'hF0});
    vecs.push_back('{8'h44, 1'b0, 1'b0, 4'b0001, 1, 0, 8'h44});
    vecs.push_back('{8'hF0, 1'b0, 1'b0, 4'b0001, 1, 0, 8'hF0});
    vecs.push_back('{8'h4B, 1'b0, 1'b0, 4'b0000, 1, 0, 8'h4B});

    rst_n    = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_keys", {28'd0, keys}, 32'h0);
    check("reset_byte", {24'd0, code_byte}, 32'h0);
    check("reset_pulses", {30'd0, code_valid, frame_err}, 32'h0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      v0 = n_valid;
      e0 = n_err;
      send_frame(vecs[i].b, vecs[i].bp, vecs[i].bs);
      check($sformatf("v%0d_keys", i), {28'd0, keys}, {28'd0, vecs[i].keys});
      check($sformatf("v%0d_valid_cnt", i), n_valid - v0, vecs[i].dv);
      check($sformatf("v%0d_err_cnt", i), n_err - e0, vecs[i].de);
      check($sformatf("v%0d_byte", i), {24'd0, code_byte}, {24'd0, vecs[i].byte_exp});
      if (vecs[i].dv == 1)
        check($sformatf("v%0d_keys_with_valid", i), {28'd0, keys_at_valid}, {28'd0, vecs[i].keys});
    end

    // Stalled partial frame: start + 4 data bits, then silence.
    v0 = n_valid;
    e0 = n_err;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    ps2_data = 1'b1;
    repeat (TO + 20) @(negedge clk);
    check("timeout_err", n_err - e0, 1);
    check("timeout_valid", n_valid - v0, 0);
    check("timeout_keys", {28'd0, keys}, 32'h0);
    send_frame(8'h4B, 1'b0, 1'b0);
    check("after_timeout_keys", {28'd0, keys}, 32'h1);
    check("after_timeout_byte", {24'd0, code_byte}, 32'h4B);
    check("after_timeout_valid", n_valid - v0, 1);

    // Reset asserted in the middle of a frame.
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_keys", {28'd0, keys}, 32'h0);
    check("midrst_byte", {24'd0, code_byte}, 32'h0);
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    v0 = n_valid;
    e0 = n_err;
    send_frame(8'h44, 1'b0, 1'b0);
    check("postrst_keys", {28'd0, keys}, 32'h2);
    check("postrst_byte", {24'd0, code_byte}, 32'h44);
    check("postrst_valid", n_valid - v0, 1);
    check("postrst_err", n_err - e0, 0);

    $display("Result: errors=%0d of %0d checks", n_fail, n_chk);
    $finish;
  end

endmodule
